// File: rtl/cntr_pkg.sv
// Shared types and constants for the counter family.
package cntr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cntr_state_t;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/up_cntr.sv
// Modulo-MODULUS up counter with run/stop FSM, synchronous clamped load,
// and wrap or one-shot operation selected at start.
module up_cntr
  import cntr_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             wrap
);

  generate
    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("up_cntr: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  cntr_state_t      state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             mode_q, mode_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  // Next-state / next-count; priority stop > load > start > count.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (load) begin
      q_d = (load_val > TERM) ? TERM : load_val;
    end else if (start) begin
      state_d = RUN;
      q_d     = '0;
      mode_d  = mode;
    end else if (state_q == RUN && en) begin
      if (q_q == TERM) begin
        if (mode_q == MODE_ONESHOT) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          q_d    = '0;
          wrap_d = 1'b1;
        end
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      mode_q  <= MODE_WRAP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      busy_q  <= (state_d == RUN);
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;
  assign tc   = (q_q == TERM);

endmodule

// File: tb/tb_up_cntr.sv
// Directed bench for up_cntr: a MODULUS=16 and a MODULUS=10 instance share inputs.
module tb_up_cntr;

  logic       clk = 1'b0;
  logic       rst, en, start, stop, mode, load;
  logic [3:0] load_val;
  logic [3:0] q16, q10;
  logic       busy16, tc16, done16, wrap16;
  logic       busy10, tc10, done10, wrap10;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  up_cntr #(.WIDTH(4), .MODULUS(16)) u16 (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode),
    .load(load), .load_val(load_val),
    .q(q16), .busy(busy16), .tc(tc16), .done(done16), .wrap(wrap16)
  );

  up_cntr #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode),
    .load(load), .load_val(load_val),
    .q(q10), .busy(busy10), .tc(tc10), .done(done10), .wrap(wrap10)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    load = 1'b0; load_val = 4'd0;
    #20;
    n_total++;
    if ({q16, busy16, tc16, done16, wrap16} !== {4'd0, 4'b0000}) begin
      $display("FAIL reset_state got q=%0d b=%0b tc=%0b d=%0b w=%0b exp q=0 all 0",
               q16, busy16, tc16, done16, wrap16);
    end else n_pass++;
    #8 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if ({q16, busy16, done16, wrap16, q10, busy10, done10, wrap10} !== 14'd0) begin
        $display("FAIL idle_after_reset cyc %0d got q16=%0d b=%0b q10=%0d b=%0b exp 0",
                 i, q16, busy16, q10, busy10);
      end else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [3:0] eq;
    mode = 1'b0; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if ({q16, busy16} !== {4'd0, 1'b1}) begin
      $display("FAIL wrap_start got q=%0d b=%0b exp q=0 b=1", q16, busy16);
    end else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      tick();
      eq = 4'(i % 16);
      n_total++;
      if ({q16, busy16, tc16, done16, wrap16} !==
          {eq, 1'b1, (eq == 4'd15), 1'b0, (i == 16)}) begin
        $display("FAIL wrap_count step %0d got q=%0d b=%0b tc=%0b d=%0b w=%0b exp q=%0d",
                 i, q16, busy16, tc16, done16, wrap16, eq);
      end else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    mode = 1'b1; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      n_total++;
      if ({q10, busy10, tc10, done10, wrap10} !==
          {4'(i), 1'b1, (i == 9), 1'b0, 1'b0}) begin
        $display("FAIL oneshot_count step %0d got q=%0d b=%0b tc=%0b d=%0b exp q=%0d",
                 i, q10, busy10, tc10, done10, i);
      end else n_pass++;
    end
    tick();
    n_total++;
    if ({q10, busy10, tc10, done10, wrap10} !== {4'd9, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL oneshot_done got q=%0d b=%0b d=%0b w=%0b exp q=9 b=0 d=1 w=0",
               q10, busy10, done10, wrap10);
    end else n_pass++;
    tick();
    tick();
    n_total++;
    if ({q10, busy10, done10} !== {4'd9, 1'b0, 1'b0}) begin
      $display("FAIL oneshot_hold got q=%0d b=%0b d=%0b exp q=9 b=0 d=0", q10, busy10, done10);
    end else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if ({q10, busy10} !== {4'd0, 1'b1}) begin
      $display("FAIL oneshot_restart got q=%0d b=%0b exp q=0 b=1", q10, busy10);
    end else n_pass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_en_toggle();
    logic       en_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] q_seq  [4] = '{4'd6, 4'd6, 4'd6, 4'd7};
    mode = 1'b0; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    n_total++;
    if (q16 !== 4'd5) $display("FAIL en_reach5 got q=%0d exp 5", q16);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      en = en_seq[i];
      tick();
      n_total++;
      if ({q16, busy16, wrap16} !== {q_seq[i], 1'b1, 1'b0}) begin
        $display("FAIL en_toggle step %0d got q=%0d b=%0b exp q=%0d b=1", i, q16, busy16, q_seq[i]);
      end else n_pass++;
    end
    en = 1'b1; stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    n_total++;
    if ({q16, busy16} !== {4'd7, 1'b0}) begin
      $display("FAIL stop_hold got q=%0d b=%0b exp q=7 b=0", q16, busy16);
    end else n_pass++;
    tick();
    n_total++;
    if ({q16, busy16} !== {4'd7, 1'b0}) begin
      $display("FAIL stop_idle_ignores_en got q=%0d b=%0b exp q=7 b=0", q16, busy16);
    end else n_pass++;
  endtask

  task automatic test_load();
    en = 1'b0; mode = 1'b1;
    load = 1'b1; load_val = 4'd12;
    tick();
    n_total++;
    if ({q10, busy10, tc10, done10, wrap10} !== {4'd9, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL load_clamp got q=%0d b=%0b tc=%0b d=%0b w=%0b exp q=9 tc=1",
               q10, busy10, tc10, done10, wrap10);
    end else n_pass++;
    start = 1'b1; load_val = 4'd3;
    tick();
    start = 1'b0; load = 1'b0;
    n_total++;
    if ({q10, busy10, tc10} !== {4'd3, 1'b0, 1'b0}) begin
      $display("FAIL load_beats_start got q=%0d b=%0b tc=%0b exp q=3 b=0 tc=0", q10, busy10, tc10);
    end else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    en = 1'b1; load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0;
    n_total++;
    if ({q10, busy10, tc10, done10, wrap10} !== {4'd9, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL load_term_in_run got q=%0d b=%0b tc=%0b d=%0b w=%0b exp q=9 b=1 d=0",
               q10, busy10, tc10, done10, wrap10);
    end else n_pass++;
    tick();
    n_total++;
    if ({q10, busy10, done10} !== {4'd9, 1'b0, 1'b1}) begin
      $display("FAIL load_then_done got q=%0d b=%0b d=%0b exp q=9 b=0 d=1", q10, busy10, done10);
    end else n_pass++;
    load = 1'b1; load_val = 4'd4;
    tick();
    load = 1'b0;
    tick();
    n_total++;
    if ({q10, busy10, done10} !== {4'd4, 1'b0, 1'b0}) begin
      $display("FAIL load_in_done got q=%0d b=%0b d=%0b exp q=4 b=0 d=0", q10, busy10, done10);
    end else n_pass++;
    stop = 1'b1; load = 1'b1; load_val = 4'd2;
    tick();
    stop = 1'b0; load = 1'b0;
    n_total++;
    if ({q10, busy10} !== {4'd4, 1'b0}) begin
      $display("FAIL stop_beats_load got q=%0d b=%0b exp q=4 b=0", q10, busy10);
    end else n_pass++;
  endtask

  task automatic test_async_reset();
    mode = 1'b0; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    n_total++;
    if ({q16, busy16} !== {4'd11, 1'b1}) begin
      $display("FAIL arst_reach11 got q=%0d b=%0b exp q=11 b=1", q16, busy16);
    end else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({q16, busy16, tc16} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL arst_immediate got q=%0d b=%0b exp q=0 b=0", q16, busy16);
    end else n_pass++;
    #1 rst = 1'b0;
    repeat (3) tick();
    n_total++;
    if ({q16, busy16} !== {4'd0, 1'b0}) begin
      $display("FAIL arst_no_resume got q=%0d b=%0b exp q=0 b=0", q16, busy16);
    end else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++;
    if ({q16, busy16} !== {4'd1, 1'b1}) begin
      $display("FAIL arst_restart got q=%0d b=%0b exp q=1 b=1", q16, busy16);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_oneshot();
    test_en_toggle();
    test_load();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
